md_unit_param: RTL

Parametrised multi-cycle multiply/divide unit for the EX stage. It is the successor of the fixed 32-bit multiply_divide block, and adds configurable width and latencies, multiply-accumulate ops, a done pulse and a divide-by-zero flag. The unit latches operands on start and commits HI/LO after a fixed latency. A pending operation is cancelled by an exception/interrupt request (req) from CP0.

---
 rtl/md_unit_param_if.sv | 32 +++
 rtl/md_unit_param.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/md_unit_param_if.sv
// Purpose : handshake/data bundle between the EX stage and md_unit_param.
// Latency : n/a (wires only).
// Backpressure: busy from the unit tells the pipeline to hold md/mfhi/mflo ops.
//
// Signals (master = pipeline side, slave = multiply/divide unit):
//   start, op[3:0], d1, d2, req   master -> slave
//   busy, done, div_zero          slave  -> master
//   hi_out, lo_out                slave  -> master (architectural HI/LO)
interface md_unit_param_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] d1;
    logic [WIDTH-1:0] d2;
    logic             req;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;

    modport master (
        output start, op, d1, d2, req,
        input  busy, done, div_zero, hi_out, lo_out
    );

    modport slave (
        input  start, op, d1, d2, req,
        output busy, done, div_zero, hi_out, lo_out
    );
endinterface

// File: rtl/md_unit_param.sv
// Purpose : multi-cycle multiply / divide / multiply-accumulate unit with HI/LO registers.
// Latency : MUL_CYCLES busy cycles for mult/madd/msub, DIV_CYCLES for div; mthi/mtlo take effect at the start edge.
// Backpressure: busy stalls the pipeline; start while busy is ignored; req cancels a pending op and blocks a new start.
//
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   bus (slave)    start/op/d1/d2/req in; busy/done/div_zero/hi_out/lo_out out
module md_unit_param #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic             clk,
    input  logic             reset,
    md_unit_param_if.slave   bus
);
    localparam int W2      = 2 * WIDTH;
    localparam int MAX_LAT = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    localparam logic [CNT_W-1:0] MUL_LAT = CNT_W'(MUL_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LAT = CNT_W'(DIV_CYCLES);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MADD  = 4'd5;
    localparam logic [3:0] OP_MADDU = 4'd6;
    localparam logic [3:0] OP_MSUB  = 4'd7;
    localparam logic [3:0] OP_MSUBU = 4'd8;
    localparam logic [3:0] OP_MTHI  = 4'd9;
    localparam logic [3:0] OP_MTLO  = 4'd10;

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       op_q, op_d;
    logic [W2-1:0]    res_q, res_d;     // pending product or {remainder, quotient}
    logic             zero_q, zero_d;   // pending divide had a zero divisor
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;
    logic             dz_q, dz_d;

    // ------------------------------------------------------------------
    // Operand decode and arithmetic on the live inputs. The result is
    // captured at the start edge, so the counter only models latency.
    // ------------------------------------------------------------------
    logic             is_signed;
    logic             is_mul_op;
    logic             is_div_op;

    always_comb begin
        is_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV) ||
                    (bus.op == OP_MADD) || (bus.op == OP_MSUB);
        is_mul_op = (bus.op == OP_MULT)  || (bus.op == OP_MULTU) ||
                    (bus.op == OP_MADD)  || (bus.op == OP_MADDU) ||
                    (bus.op == OP_MSUB)  || (bus.op == OP_MSUBU);
        is_div_op = (bus.op == OP_DIV)   || (bus.op == OP_DIVU);
    end

    // Sign- or zero-extend to 2*WIDTH; the low 2*WIDTH bits of the product
    // of the extended operands are the exact signed/unsigned product.
    logic [W2-1:0] mul_a;
    logic [W2-1:0] mul_b;
    logic [W2-1:0] prod;

    always_comb begin
        mul_a = {{WIDTH{is_signed & bus.d1[WIDTH-1]}}, bus.d1};
        mul_b = {{WIDTH{is_signed & bus.d2[WIDTH-1]}}, bus.d2};
        prod  = mul_a * mul_b;
    end

    // Signed divide runs on magnitudes through one unsigned divider. The
    // -2^(W-1) / -1 case falls out naturally: |d1| = 2^(W-1) as unsigned,
    // negating it yields -2^(W-1) again and the remainder is 0.
    logic             d1_neg;
    logic             d2_neg;
    logic             div_by_zero;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] dvs_safe;
    logic [WIDTH-1:0] q_abs;
    logic [WIDTH-1:0] r_abs;
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] rem;

    always_comb begin
        d1_neg      = is_signed & bus.d1[WIDTH-1];
        d2_neg      = is_signed & bus.d2[WIDTH-1];
        div_by_zero = (bus.d2 == '0);
        dvd         = d1_neg ? (-bus.d1) : bus.d1;
        dvs         = d2_neg ? (-bus.d2) : bus.d2;
        // Keep the divider defined on a zero divisor; the result is discarded.
        dvs_safe    = div_by_zero ? WIDTH'(1) : dvs;
        q_abs       = dvd / dvs_safe;
        r_abs       = dvd % dvs_safe;
        quot        = (d1_neg ^ d2_neg) ? (-q_abs) : q_abs;
        rem         = d1_neg ? (-r_abs) : r_abs;
    end

    // ------------------------------------------------------------------
    // Commit value: accumulate ops fold the stored product into the
    // current HI/LO; a zero-divisor divide leaves HI/LO untouched.
    // ------------------------------------------------------------------
    logic [W2-1:0] acc;
    logic [W2-1:0] commit_val;

    always_comb begin
        acc = {hi_q, lo_q};
        case (op_q)
            OP_MADD, OP_MADDU: commit_val = acc + res_q;
            OP_MSUB, OP_MSUBU: commit_val = acc - res_q;
            OP_DIV, OP_DIVU:   commit_val = zero_q ? acc : res_q;
            default:           commit_val = res_q;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        res_d   = res_q;
        zero_d  = zero_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        dz_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.req) begin
                    if (is_mul_op) begin
                        op_d    = bus.op;
                        res_d   = prod;
                        zero_d  = 1'b0;
                        cnt_d   = MUL_LAT;
                        state_d = S_RUN;
                    end else if (is_div_op) begin
                        op_d    = bus.op;
                        res_d   = {rem, quot};
                        zero_d  = div_by_zero;
                        cnt_d   = DIV_LAT;
                        state_d = S_RUN;
                    end else if (bus.op == OP_MTHI) begin
                        hi_d = bus.d1;
                    end else if (bus.op == OP_MTLO) begin
                        lo_d = bus.d1;
                    end
                end
            end

            S_RUN: begin
                if (bus.req) begin
                    // Cancel: drop the pending result, HI/LO keep pre-op values.
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d      = S_IDLE;
                        done_d       = 1'b1;
                        dz_d         = zero_q;
                        {hi_d, lo_d} = commit_val;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            res_q   <= '0;
            zero_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
        end
    end

    assign bus.busy     = (state_q == S_RUN);
    assign bus.done     = done_q;
    assign bus.div_zero = dz_q;
    assign bus.hi_out   = hi_q;
    assign bus.lo_out   = lo_q;

endmodule
